// File: rtl/grid_scan_controller.sv
// Grid RAM sequencer: a start press clears every row, then rows are read back through a
// fixed-latency RAM port and streamed out over valid/ready with full-row and end-of-frame flags.
module grid_scan_controller #(
    parameter int unsigned GRID_COLS    = 10,
    parameter int unsigned GRID_ROWS    = 20,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned READ_LATENCY = 1,
    parameter logic [3:0]  START_CODE   = 4'h4,
    parameter bit          CONTINUOUS   = 1'b1
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic [3:0]           controller_in,
    input  logic [GRID_COLS-1:0] grid_data_in,
    output logic [ADDR_W-1:0]    grid_address,
    output logic                 grid_wr_en,
    output logic [GRID_COLS-1:0] grid_wr_data,
    output logic                 game_reset,
    output logic [GRID_COLS-1:0] row_data,
    output logic [ADDR_W-1:0]    row_index,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic                 row_full,
    output logic                 frame_done,
    output logic                 busy
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_ADDR  = 3'd2,
        S_WAIT  = 3'd3,
        S_DATA  = 3'd4,
        S_HOLD  = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'(GRID_ROWS - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
    localparam logic [2:0]        LAT_LOAD = 3'(READ_LATENCY);

    state_t                state_q, state_d;
    logic                  start_prev_q;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  wr_en_q, wr_en_d;
    logic                  game_reset_q, game_reset_d;
    logic [GRID_COLS-1:0]  row_data_q, row_data_d;
    logic [ADDR_W-1:0]     row_index_q, row_index_d;
    logic                  row_valid_q, row_valid_d;
    logic                  row_full_q, row_full_d;
    logic                  frame_done_q, frame_done_d;
    logic                  busy_q, busy_d;
    logic [2:0]            lat_cnt_q, lat_cnt_d;

    logic start_s, start_acc_s, last_row_s, handshake_s;

    assign start_s     = (controller_in == START_CODE);
    assign start_acc_s = start_s & ~start_prev_q;
    assign last_row_s  = (addr_q == LAST_ROW);
    assign handshake_s = row_valid_q & row_ready;

    // State and registered-output flops.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= S_IDLE;
            start_prev_q <= 1'b0;
            addr_q       <= {ADDR_W{1'b0}};
            wr_en_q      <= 1'b0;
            game_reset_q <= 1'b0;
            row_data_q   <= {GRID_COLS{1'b0}};
            row_index_q  <= {ADDR_W{1'b0}};
            row_valid_q  <= 1'b0;
            row_full_q   <= 1'b0;
            frame_done_q <= 1'b0;
            busy_q       <= 1'b0;
            lat_cnt_q    <= 3'd0;
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_s;
            addr_q       <= addr_d;
            wr_en_q      <= wr_en_d;
            game_reset_q <= game_reset_d;
            row_data_q   <= row_data_d;
            row_index_q  <= row_index_d;
            row_valid_q  <= row_valid_d;
            row_full_q   <= row_full_d;
            frame_done_q <= frame_done_d;
            busy_q       <= busy_d;
            lat_cnt_q    <= lat_cnt_d;
        end
    end

    // Next-state logic; a fresh start press overrides every state.
    always_comb begin
        state_d = state_q;
        if (start_acc_s) begin
            state_d = S_CLEAR;
        end else begin
            case (state_q)
                S_IDLE:  state_d = S_IDLE;
                S_CLEAR: state_d = last_row_s ? S_ADDR : S_CLEAR;
                S_ADDR:  state_d = S_WAIT;
                S_WAIT:  state_d = (lat_cnt_q == 3'd1) ? S_DATA : S_WAIT;
                S_DATA:  state_d = S_HOLD;
                S_HOLD: begin
                    if (handshake_s) begin
                        if (last_row_s) begin
                            state_d = (CONTINUOUS != 1'b0) ? S_ADDR : S_IDLE;
                        end else begin
                            state_d = S_ADDR;
                        end
                    end else begin
                        state_d = S_HOLD;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // Output/datapath next values; the address only moves in CLEAR or on a row handshake.
    always_comb begin
        addr_d       = addr_q;
        wr_en_d      = 1'b0;
        game_reset_d = 1'b0;
        row_data_d   = row_data_q;
        row_index_d  = row_index_q;
        row_valid_d  = row_valid_q;
        row_full_d   = row_full_q;
        frame_done_d = 1'b0;
        lat_cnt_d    = lat_cnt_q;
        if (start_acc_s) begin
            game_reset_d = 1'b1;
            row_valid_d  = 1'b0;
            addr_d       = {ADDR_W{1'b0}};
            wr_en_d      = 1'b1;
        end else begin
            case (state_q)
                S_IDLE:  row_valid_d = 1'b0;
                S_CLEAR: begin
                    if (last_row_s) begin
                        addr_d  = {ADDR_W{1'b0}};
                        wr_en_d = 1'b0;
                    end else begin
                        addr_d  = addr_q + ADDR_ONE;
                        wr_en_d = 1'b1;
                    end
                end
                S_ADDR:  lat_cnt_d = LAT_LOAD;
                S_WAIT:  lat_cnt_d = lat_cnt_q - 3'd1;
                S_DATA: begin
                    row_data_d  = grid_data_in;
                    row_index_d = addr_q;
                    row_full_d  = &grid_data_in;
                    row_valid_d = 1'b1;
                end
                S_HOLD: begin
                    if (handshake_s) begin
                        row_valid_d = 1'b0;
                        if (last_row_s) begin
                            frame_done_d = 1'b1;
                            addr_d       = {ADDR_W{1'b0}};
                        end else begin
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end else begin
                        row_valid_d = 1'b1;
                    end
                end
                default: begin
                    addr_d      = {ADDR_W{1'b0}};
                    row_valid_d = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != S_IDLE);
    end

    assign grid_address = addr_q;
    assign grid_wr_en   = wr_en_q;
    assign grid_wr_data = {GRID_COLS{1'b0}};
    assign game_reset   = game_reset_q;
    assign row_data     = row_data_q;
    assign row_index    = row_index_q;
    assign row_valid    = row_valid_q;
    assign row_full     = row_full_q;
    assign frame_done   = frame_done_q;
    assign busy         = busy_q;

endmodule

// File: doc/grid_scan_controller.md
Name: grid_scan_controller

Overview:
Parametrised successor to the single-grid address/data sequencer. It clears the Tetris grid RAM on a start-button press, then scans the grid row by row through a synchronous-read memory port with configurable read latency. Each row is presented on a valid/ready stream to the renderer/line-clear logic, with full-row detection and per-frame completion. It sits between the controller input decoder and the grid RAM.

Parameters:
GRID_COLS, 10, cells per row; equals the RAM word width (one word per row)
GRID_ROWS, 20, rows in grid; RAM addresses 0..GRID_ROWS-1
ADDR_W, 8, grid address width; GRID_ROWS <= 2**ADDR_W
READ_LATENCY, 1, clocks from address presented to data valid on grid_data_in (1..4)
START_CODE, 4'h4, controller_in value that means the start button is pressed
CONTINUOUS, 1, 1: rescan from row 0 after each frame; 0: return to IDLE after one frame

Ports:
clock  in  1  system clock, all logic on rising edge
reset_n  in  1  asynchronous active-low reset
controller_in  in  4  decoded controller button code
grid_data_in  in  GRID_COLS  RAM read data (one row)
grid_address  out  ADDR_W  RAM address (registered)
grid_wr_en  out  1  RAM write enable (clear phase only)
grid_wr_data  out  GRID_COLS  RAM write data (always zero)
game_reset  out  1  one-cycle pulse on accepted start press
row_data  out  GRID_COLS  captured row contents
row_index  out  ADDR_W  row number of row_data
row_valid  out  1  row_data/row_index/row_full valid
row_ready  in  1  downstream accepts row when row_valid & row_ready
row_full  out  1  all GRID_COLS bits of row_data set; qualified by row_valid
frame_done  out  1  one-cycle pulse after last row is accepted
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (reset_n low, async): state IDLE; grid_address 0; grid_wr_en 0; grid_wr_data 0; game_reset 0; row_data 0; row_index 0; row_valid 0; row_full 0; frame_done 0; busy 0; start-edge register 0.
- Start detection: start = (controller_in == START_CODE). Accepted on rising edge only (registered previous value). Holding the button does not retrigger.
- Accepted start, in any state, takes priority over all else: game_reset pulses 1 cycle; row_valid drops; next state CLEAR with grid_address 0. Mid-scan and mid-clear presses restart cleanly.
- States:
  IDLE: outputs quiescent; waits for accepted start.
  CLEAR: grid_wr_en=1, grid_wr_data=0, grid_address increments each cycle 0..GRID_ROWS-1 (GRID_ROWS cycles); after the last write, grid_wr_en=0, grid_address=0, go ADDR.
  ADDR: address stable; load latency counter with READ_LATENCY; go WAIT.
  WAIT: decrement counter; when it reaches 0, go DATA. Data is sampled exactly READ_LATENCY cycles after the first ADDR cycle.
  DATA: register row_data=grid_data_in, row_index=grid_address, row_full=&grid_data_in; assert row_valid; go HOLD.
  HOLD: row_valid held and row_* stable until row_ready=1. On handshake: row_valid 0; if grid_address==GRID_ROWS-1 then pulse frame_done, grid_address=0, next ADDR if CONTINUOUS else IDLE; otherwise grid_address+1, next ADDR.
- Backpressure: grid_address never advances while a row is pending; no row is dropped or duplicated.
- row_ready while row_valid=0 is ignored.
- Address arithmetic is ADDR_W bits; wrap is explicit at GRID_ROWS-1, never at 2**ADDR_W.
- Minimum per-row period with row_ready tied high: READ_LATENCY+3 cycles.
- grid_wr_en is never asserted outside CLEAR.

Test Plan:
- Defaults; reset_n low mid-HOLD, release -> all outputs 0, state IDLE, busy 0.
- controller_in 0->4 and held 50 cycles -> exactly one game_reset pulse; 20 consecutive writes of 0 to addresses 0..19; then reads begin at address 0.
- RAM row 5 = 10'h3FF, others 10'h155, row_ready=1 -> 20 rows in order; row_full=1 only on row_index 5; frame_done pulse after row 19; rescan from 0.
- row_ready low 7 cycles on row 3 -> row_valid, row_data, row_index=3 stable; grid_address stays 3; row 4 follows handshake.
- READ_LATENCY=3 with 3-stage RAM model -> every row_data matches RAM contents; period 6 cycles per row.
- Start press during row 12 HOLD with CONTINUOUS=0 -> row_valid drops, CLEAR of 20 rows, full frame, frame_done, then IDLE with busy 0.
